// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning block: FSM state
// encoding and a constant-function ceil(log2) used to size the timer.
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; q is the last
// stage and is safe to use in the clk domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Turns a raw button into a single-cycle counter enable: synchronize,
// debounce press and release, then optionally auto-repeat while held.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse,
  output logic btn_level,
  output logic held
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int TW = clog2(MAX_CYCLES) + 1;

  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
  localparam logic          REP_ON    = (REPEAT_EN != 0);

  logic          btn_s;
  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic          pulse_next, level_next, held_next;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      pulse     <= 1'b0;
      btn_level <= 1'b0;
      held      <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      pulse     <= pulse_next;
      btn_level <= level_next;
      held      <= held_next;
    end
  end

  // In every waiting state a drop of btn_s is tested before the terminal
  // count, so a release coinciding with the timer end never produces a pulse.
  always_comb begin
    state_next = state;
    timer_next = timer;
    pulse_next = 1'b0;
    level_next = btn_level;
    held_next  = held;
    case (state)
      ST_IDLE: begin
        if (btn_s) begin
          state_next = ST_PRESS_WAIT;
          timer_next = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end else if (timer == DEB_LAST) begin
          state_next = ST_PRESSED;
          timer_next = '0;
          pulse_next = 1'b1;
          level_next = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_next = ST_RELEASE_WAIT;
          timer_next = '0;
          held_next  = 1'b0;
        end else if (REP_ON && (timer == HOLD_LAST)) begin
          state_next = ST_REPEAT;
          timer_next = '0;
          pulse_next = 1'b1;
          held_next  = 1'b1;
        end else if (timer != HOLD_LAST) begin
          timer_next = timer + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!btn_s) begin
          state_next = ST_RELEASE_WAIT;
          timer_next = '0;
          held_next  = 1'b0;
        end else if (timer == REP_LAST) begin
          timer_next = '0;
          pulse_next = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        held_next = 1'b0;
        if (btn_s) begin
          state_next = ST_PRESSED;
          timer_next = '0;
        end else if (timer == DEB_LAST) begin
          state_next = ST_IDLE;
          timer_next = '0;
          level_next = 1'b0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
        level_next = 1'b0;
        held_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with short timer parameters; three
// instances cover auto-repeat on, auto-repeat off and single-cycle debounce.
module tb_btn_debounce_pulse;

  logic clk;
  logic reset;
  logic btn_in;
  logic pulse_rep, level_rep, held_rep;
  logic pulse_norep, level_norep, held_norep;
  logic pulse_deb1, level_deb1, held_deb1;

  int check_count;
  int pass_count;
  int edge_num;
  logic [7:0] count_rep;
  logic [7:0] count_norep;
  logic [7:0] count_deb1;

  typedef struct {
    logic btn;
    logic exp_pulse;
    logic exp_level;
    logic exp_held;
    logic exp_pulse_deb1;
  } vec_t;

  vec_t vecs[20];

  btn_debounce_pulse #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3), .REPEAT_EN(1)
  ) dut_rep (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .pulse(pulse_rep), .btn_level(level_rep), .held(held_rep)
  );

  btn_debounce_pulse #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3), .REPEAT_EN(0)
  ) dut_norep (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .pulse(pulse_norep), .btn_level(level_norep), .held(held_norep)
  );

  btn_debounce_pulse #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3), .REPEAT_EN(0)
  ) dut_deb1 (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .pulse(pulse_deb1), .btn_level(level_deb1), .held(held_deb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next edge, then sample 1 time unit after it.
  task automatic applyStimulus(input logic btn, input logic rst);
    btn_in = btn;
    reset  = rst;
    @(posedge clk);
    #1;
    edge_num++;
    if (pulse_rep)   count_rep++;
    if (pulse_norep) count_norep++;
    if (pulse_deb1)  count_deb1++;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_num, actual, expected);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    reset     = 1'b0;
    edge_num  = 0;
    count_rep = 0;
    count_norep = 0;
    count_deb1  = 0;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    edge_num    = 0;
    btn_in      = 1'b0;
    reset       = 1'b1;

    // Clean press, high for edges 1..12: accept at edge 7, release seen at
    // edge 15, level drops after the 4-cycle release debounce at edge 19.
    for (int i = 0; i < 20; i++) begin
      vecs[i].btn            = ((i + 1) <= 12);
      vecs[i].exp_pulse      = ((i + 1) == 7);
      vecs[i].exp_level      = ((i + 1) >= 7) && ((i + 1) <= 18);
      vecs[i].exp_held       = 1'b0;
      vecs[i].exp_pulse_deb1 = ((i + 1) == 4);
    end

    resetDut();
    $display("[TB] reset state");
    checkOutput("reset_pulse", pulse_rep, 0);
    checkOutput("reset_level", level_rep, 0);
    checkOutput("reset_held",  held_rep,  0);

    $display("[TB] scenario 1: clean press");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].btn, 1'b0);
      checkOutput("clean_pulse", pulse_rep, vecs[i].exp_pulse);
      checkOutput("clean_level", level_rep, vecs[i].exp_level);
      checkOutput("clean_held",  held_rep,  vecs[i].exp_held);
      checkOutput("deb1_pulse",  pulse_deb1, vecs[i].exp_pulse_deb1);
    end
    checkOutput("clean_count", count_rep, 1);
    checkOutput("deb1_count",  count_deb1, 1);

    $display("[TB] scenario 2: bouncy press");
    resetDut();
    for (int e = 1; e <= 16; e++) begin
      logic bounce;
      case (e)
        1: bounce = 1'b1;
        2: bounce = 1'b0;
        3: bounce = 1'b1;
        4: bounce = 1'b1;
        5: bounce = 1'b0;
        default: bounce = 1'b1;
      endcase
      applyStimulus(bounce, 1'b0);
      checkOutput("bounce_pulse", pulse_norep, (e == 12) ? 1 : 0);
    end
    checkOutput("bounce_count", count_norep, 1);

    // Long hold: btn_in high on edges 1..29, so the synchronized drop
    // lands exactly on the repeat terminal count at edge 32 and must win.
    $display("[TB] scenarios 3/4: long hold with and without repeat");
    resetDut();
    for (int e = 1; e <= 40; e++) begin
      logic exp_p;
      exp_p = (e == 7) || (e == 17) || (e == 20) || (e == 23) || (e == 26) || (e == 29);
      applyStimulus((e <= 29), 1'b0);
      checkOutput("hold_pulse", pulse_rep, exp_p);
      if (e == 16 || e == 17 || e == 31 || e == 32)
        checkOutput("hold_held", held_rep, (e == 17 || e == 31) ? 1 : 0);
      checkOutput("norep_held", held_norep, 0);
    end
    checkOutput("hold_count",  count_rep, 6);
    checkOutput("norep_count", count_norep, 1);
    checkOutput("hold_level_after", level_rep, 0);

    // Glitch: input low on edges 9 and 10 while PRESSED, final release after 14.
    $display("[TB] scenario 5: release glitch");
    resetDut();
    for (int e = 1; e <= 24; e++) begin
      applyStimulus(!(e == 9 || e == 10 || e > 14), 1'b0);
      if (e >= 7 && e <= 20) checkOutput("glitch_level", level_rep, 1);
      if (e == 21) checkOutput("glitch_level_off", level_rep, 0);
    end
    checkOutput("glitch_count", count_rep, 1);

    $display("[TB] scenario 6: reset during repeat");
    resetDut();
    for (int e = 1; e <= 18; e++) applyStimulus(1'b1, 1'b0);
    checkOutput("pre_reset_held", held_rep, 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rst_pulse", pulse_rep, 0);
    checkOutput("rst_held",  held_rep,  0);
    checkOutput("rst_level", level_rep, 0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("after_rst_pulse", pulse_rep, (k == 7) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
